// File: rtl/gb_pkg.sv
// Shared Game Boy core definitions: IO register addresses and the OAM DMA state encoding.
package gb_pkg;

    localparam logic [15:0] TIMER_DIV_REG  = 16'hff04;
    localparam logic [15:0] TIMER_TIMA_REG = 16'hff05;
    localparam logic [15:0] TIMER_TMA_REG  = 16'hff06;
    localparam logic [15:0] TIMER_TAC_REG  = 16'hff07;
    localparam logic [15:0] LINK_SB_REG    = 16'hff01;
    localparam logic [15:0] LINK_SC_REG    = 16'hff02;
    localparam logic [15:0] INT_IF_REG     = 16'hff0f;
    localparam logic [15:0] INT_IE_REG     = 16'hffff;
    localparam logic [15:0] OAM_DMA_REG    = 16'hff46;
    localparam logic [15:0] OAM_BASE       = 16'hfe00;
    localparam int          OAM_LENGTH     = 160;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } dma_state_t;

endpackage

// File: rtl/oam_dma_if.sv
// CPU-side register port plus the DMA master port, as seen on the shared bus.
interface oam_dma_if;
    logic [15:0] address;
    logic [7:0]  indata;
    logic [7:0]  outdata;
    logic        load;
    logic        store;
    logic        busy;
    logic [15:0] dma_address;
    logic [7:0]  dma_wdata;
    logic [7:0]  dma_rdata;
    logic        dma_load;
    logic        dma_store;

    // slave: the DMA block's view; master: the bus/top-level side.
    modport slave (
        input  address, indata, load, store, dma_rdata,
        output outdata, busy, dma_address, dma_wdata, dma_load, dma_store
    );
    modport master (
        output address, indata, load, store, dma_rdata,
        input  outdata, busy, dma_address, dma_wdata, dma_load, dma_store
    );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA engine: a write to the DMA register copies LENGTH bytes from {src,00} to DEST_BASE.
// Optional OAM_DMA_DEBUG_EN adds the ddma debug port.
module oam_dma
    import gb_pkg::*;
#(
    parameter logic [15:0] REG_ADDR  = OAM_DMA_REG,
    parameter logic [15:0] DEST_BASE = OAM_BASE,
    parameter int          LENGTH    = OAM_LENGTH
) (
    input  logic        clock,
    input  logic        resetn,
    oam_dma_if.slave    bus
`ifdef OAM_DMA_DEBUG_EN
    ,
    output logic [15:0] ddma
`endif
);

    localparam logic [7:0] LAST_IDX = 8'(LENGTH - 1);

    dma_state_t state, state_nx;
    logic [7:0] src, src_nx;
    logic [7:0] idx, idx_nx;
    logic [7:0] latch, latch_nx;
    logic       reg_write;

    assign reg_write   = bus.store && (bus.address == REG_ADDR);
    assign bus.outdata = (bus.load && (bus.address == REG_ADDR)) ? src : 8'h00;
    assign bus.busy    = (state != IDLE);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            src   <= 8'h00;
            idx   <= 8'h00;
            latch <= 8'h00;
        end else begin
            state <= state_nx;
            src   <= src_nx;
            idx   <= idx_nx;
            latch <= latch_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        src_nx          = src;
        idx_nx          = idx;
        latch_nx        = latch;
        bus.dma_address = 16'h0000;
        bus.dma_wdata   = 8'h00;
        bus.dma_load    = 1'b0;
        bus.dma_store   = 1'b0;

        case (state)
            READ: begin
                // idx is the low byte, so a source page of FF never carries into 0000
                bus.dma_address = {src, idx};
                bus.dma_load    = 1'b1;
                latch_nx        = bus.dma_rdata;
                state_nx        = WRITE;
            end
            WRITE: begin
                bus.dma_address = DEST_BASE + {8'h00, idx};
                bus.dma_wdata   = latch;
                bus.dma_store   = 1'b1;
                if (idx == LAST_IDX) begin
                    state_nx = IDLE;
                end else begin
                    idx_nx   = idx + 8'd1;
                    state_nx = READ;
                end
            end
            default: ;
        endcase

        // A register write restarts from index 0 in any state; the current strobe still completes.
        if (reg_write) begin
            src_nx   = bus.indata;
            idx_nx   = 8'h00;
            state_nx = READ;
        end
    end

`ifdef OAM_DMA_DEBUG_EN
    assign ddma = {6'b0, 2'(state), idx};
`endif

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: memory model on the master port, event monitor, reference transfer model.
module tb_oam_dma;
    import gb_pkg::*;

    typedef struct packed {
        logic        st;
        logic [15:0] addr;
        logic [7:0]  data;
    } ev_t;

    logic clock = 1'b0;
    logic resetn;
    oam_dma_if bus ();

    always #5 clock = ~clock;

`ifdef OAM_DMA_DEBUG_EN
    logic [15:0] ddma;
    oam_dma dut (.clock(clock), .resetn(resetn), .bus(bus), .ddma(ddma));
`else
    oam_dma dut (.clock(clock), .resetn(resetn), .bus(bus));
`endif

    logic [7:0] mem [0:65535];
    assign bus.dma_rdata = bus.dma_load ? mem[bus.dma_address] : 8'h00;

    always @(posedge clock) begin
        if (bus.dma_store) mem[bus.dma_address] = bus.dma_wdata;
    end

    ev_t ev_q[$];
    ev_t exp_q[$];
    logic [7:0] exp_dst [0:159];
    int busy_cnt, overlap_cnt, idle_strobe_cnt;
    int checks = 0;
    int failures = 0;

    always @(negedge clock) begin
        if (bus.busy) busy_cnt++;
        if (bus.dma_load && bus.dma_store) overlap_cnt++;
        if (!bus.busy && (bus.dma_load || bus.dma_store)) idle_strobe_cnt++;
        if (bus.dma_load)
            ev_q.push_back('{st: 1'b0, addr: bus.dma_address, data: bus.dma_rdata});
        else if (bus.dma_store)
            ev_q.push_back('{st: 1'b1, addr: bus.dma_address, data: bus.dma_wdata});
    end

    // Expected transfer: byte i is read from {s,i} then written to FE00+i, alternating.
    task automatic build_model(input logic [7:0] s);
        exp_q.delete();
        for (int i = 0; i < 160; i++) begin
            logic [15:0] a;
            a = {s, 8'(i)};
            exp_dst[i] = mem[a];
            exp_q.push_back('{st: 1'b0, addr: a, data: mem[a]});
            exp_q.push_back('{st: 1'b1, addr: 16'hfe00 + 16'(i), data: mem[a]});
        end
    endtask

    function automatic int ev_errors();
        int n;
        n = (ev_q.size() > exp_q.size()) ? ev_q.size() - exp_q.size() : exp_q.size() - ev_q.size();
        for (int i = 0; i < ev_q.size() && i < exp_q.size(); i++)
            if (ev_q[i] !== exp_q[i]) n++;
        return n;
    endfunction

    function automatic int dst_errors();
        int n = 0;
        for (int i = 0; i < 160; i++)
            if (mem[16'hfe00 + 16'(i)] !== exp_dst[i]) n++;
        return n;
    endfunction

    task automatic clear_mon();
        ev_q.delete();
        busy_cnt = 0;
        overlap_cnt = 0;
        idle_strobe_cnt = 0;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        bus.address = a;
        bus.indata  = d;
        bus.store   = 1'b1;
        @(posedge clock); #1;
        bus.store   = 1'b0;
        bus.address = 16'h0000;
        bus.indata  = 8'h00;
    endtask

    task automatic wait_idle(input int bound, output bit timeout);
        int n = 0;
        while (bus.busy && n < bound) begin
            @(posedge clock); #1;
            n++;
        end
        timeout = bus.busy;
    endtask

    task automatic fill_page(input logic [7:0] p);
        for (int i = 0; i < 256; i++) mem[{p, 8'(i)}] = 8'($urandom);
    endtask

    task automatic test_reset();
        bus.address = OAM_DMA_REG; bus.indata = 8'h00; bus.load = 1'b1; bus.store = 1'b0;
        resetn = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.dma_load !== 1'b0 || bus.dma_store !== 1'b0) begin failures++; $display("FAIL reset_strobes got=%b%b exp=00", bus.dma_load, bus.dma_store); end
        checks++; if (bus.dma_address !== 16'h0000 || bus.dma_wdata !== 8'h00) begin failures++; $display("FAIL reset_bus got=%h/%h exp=0000/00", bus.dma_address, bus.dma_wdata); end
        checks++; if (bus.outdata !== 8'h00) begin failures++; $display("FAIL reset_src got=%h exp=00", bus.outdata); end
        bus.load = 1'b0; bus.address = 16'h0000;
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_basic();
        bit to;
        logic [7:0] sentinel;
        for (int i = 0; i < 160; i++) mem[16'hc000 + 16'(i)] = 8'(i) ^ 8'h5a;
        fill_page(8'hfe);
        sentinel = mem[16'hfea0];
        build_model(8'hc0);
        clear_mon();
        cpu_write(OAM_DMA_REG, 8'hc0);
        checks++; if (bus.busy !== 1'b1 || bus.dma_load !== 1'b1) begin failures++; $display("FAIL basic_first_cycle got busy=%b load=%b exp=1/1", bus.busy, bus.dma_load); end
        checks++; if (bus.dma_address !== 16'hc000) begin failures++; $display("FAIL basic_first_addr got=%h exp=c000", bus.dma_address); end
        wait_idle(1000, to);
        checks++; if (to) begin failures++; $display("FAIL basic_timeout got=busy exp=idle"); end
        checks++; if (busy_cnt !== 320) begin failures++; $display("FAIL basic_busy_len got=%0d exp=320", busy_cnt); end
        checks++; if (ev_errors() !== 0) begin failures++; $display("FAIL basic_strobe_seq got=%0d errors (%0d events) exp=0 (320)", ev_errors(), ev_q.size()); end
        checks++; if (overlap_cnt !== 0 || idle_strobe_cnt !== 0) begin failures++; $display("FAIL basic_overlap got=%0d/%0d exp=0/0", overlap_cnt, idle_strobe_cnt); end
        checks++; if (dst_errors() !== 0) begin failures++; $display("FAIL basic_oam_data got=%0d errors exp=0", dst_errors()); end
        checks++; if (mem[16'hfea0] !== sentinel) begin failures++; $display("FAIL basic_fea0 got=%h exp=%h", mem[16'hfea0], sentinel); end
    endtask

    task automatic test_readback();
        bus.load = 1'b1; bus.address = OAM_DMA_REG;
        #1;
        checks++; if (bus.outdata !== 8'hc0) begin failures++; $display("FAIL read_ff46 got=%h exp=c0", bus.outdata); end
        bus.address = 16'hff45;
        #1;
        checks++; if (bus.outdata !== 8'h00) begin failures++; $display("FAIL read_ff45 got=%h exp=00", bus.outdata); end
        bus.load = 1'b0; bus.address = OAM_DMA_REG;
        #1;
        checks++; if (bus.outdata !== 8'h00) begin failures++; $display("FAIL read_noload got=%h exp=00", bus.outdata); end
        bus.address = 16'h0000;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL read_no_start got=%b exp=0", bus.busy); end
    endtask

    task automatic test_restart();
        bit to;
        fill_page(8'hc0);
        fill_page(8'hc1);
        fill_page(8'hfe);
        cpu_write(OAM_DMA_REG, 8'hc0);
        repeat (49) begin @(posedge clock); #1; end
        build_model(8'hc1);
        cpu_write(OAM_DMA_REG, 8'hc1);
        clear_mon();
        checks++; if (bus.dma_load !== 1'b1 || bus.dma_address !== 16'hc100) begin failures++; $display("FAIL restart_first got load=%b addr=%h exp=1/c100", bus.dma_load, bus.dma_address); end
        wait_idle(1000, to);
        checks++; if (to || busy_cnt !== 320) begin failures++; $display("FAIL restart_busy_len got=%0d timeout=%b exp=320", busy_cnt, to); end
        checks++; if (ev_errors() !== 0) begin failures++; $display("FAIL restart_strobe_seq got=%0d errors exp=0", ev_errors()); end
        checks++; if (dst_errors() !== 0) begin failures++; $display("FAIL restart_oam_data got=%0d errors exp=0", dst_errors()); end
    endtask

    task automatic test_reset_mid();
        fill_page(8'hc2);
        cpu_write(OAM_DMA_REG, 8'hc2);
        repeat (99) begin @(posedge clock); #1; end
        bus.load = 1'b1; bus.address = OAM_DMA_REG;
        resetn = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.dma_load !== 1'b0 || bus.dma_store !== 1'b0) begin failures++; $display("FAIL midreset_outputs got=%b%b%b exp=000", bus.busy, bus.dma_load, bus.dma_store); end
        checks++; if (bus.outdata !== 8'h00) begin failures++; $display("FAIL midreset_src got=%h exp=00", bus.outdata); end
        bus.load = 1'b0; bus.address = 16'h0000;
        clear_mon();
        @(posedge clock); #1;
        resetn = 1'b1;
        repeat (30) begin @(posedge clock); #1; end
        checks++; if (ev_q.size() !== 0 || busy_cnt !== 0) begin failures++; $display("FAIL midreset_quiet got=%0d strobes %0d busy exp=0/0", ev_q.size(), busy_cnt); end
    endtask

    task automatic test_src_ff();
        bit to;
        int low_reads = 0;
        fill_page(8'hff);
        build_model(8'hff);
        clear_mon();
        cpu_write(OAM_DMA_REG, 8'hff);
        wait_idle(1000, to);
        foreach (ev_q[i]) if (!ev_q[i].st && ev_q[i].addr < 16'hff00) low_reads++;
        checks++; if (to || low_reads !== 0) begin failures++; $display("FAIL srcff_wrap got=%0d low reads timeout=%b exp=0", low_reads, to); end
        checks++; if (ev_errors() !== 0) begin failures++; $display("FAIL srcff_strobe_seq got=%0d errors exp=0", ev_errors()); end
        checks++; if (dst_errors() !== 0) begin failures++; $display("FAIL srcff_oam_data got=%0d errors exp=0", dst_errors()); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3; k++) begin
            bit to;
            logic [7:0] s;
            s = 8'($urandom_range(8'h80, 8'hdf));
            fill_page(s);
            build_model(s);
            clear_mon();
            cpu_write(OAM_DMA_REG, s);
            wait_idle(1000, to);
            checks++; if (to || busy_cnt !== 320) begin failures++; $display("FAIL rand_busy_len src=%h got=%0d exp=320", s, busy_cnt); end
            checks++; if (ev_errors() !== 0 || overlap_cnt !== 0) begin failures++; $display("FAIL rand_strobe_seq src=%h got=%0d errors exp=0", s, ev_errors()); end
            checks++; if (dst_errors() !== 0) begin failures++; $display("FAIL rand_oam_data src=%h got=%0d errors exp=0", s, dst_errors()); end
        end
    endtask

    initial begin
        bus.address = 16'h0000; bus.indata = 8'h00; bus.load = 1'b0; bus.store = 1'b0;
        busy_cnt = 0; overlap_cnt = 0; idle_strobe_cnt = 0;
        test_reset();
        test_basic();
        test_readback();
        test_restart();
        test_reset_mid();
        test_src_ff();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
